// File: rtl/otter_i2c_slave.sv
// rtl/otter_i2c_slave.sv - I2C slave with pointer-addressed register file, oversampled on clk
`timescale 1ns/1ps
module otter_i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h48,
  parameter int         NUM_REGS   = 16,
  parameter logic [7:0] REG_INIT   = 8'h00,
  localparam int        PW         = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scl,
  inout  wire           sda,
  output logic          busy,
  output logic          wr_stb,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACK_ADDR, S_PTR, S_ACK_PTR, S_WR_DATA,
    S_ACK_WR, S_RD_DATA, S_RD_ACK, S_RD_LOAD, S_IGNORE
  } state_t;

  state_t        state, state_n;
  logic          scl_s1, scl_s2, scl_prev;
  logic          sda_s1, sda_s2, sda_prev;
  logic          scl_rise, scl_fall, start_det, stop_det;
  logic [3:0]    cnt;
  logic [7:0]    sh;
  logic          oe;
  logic [PW-1:0] ptr;
  logic [7:0]    regs [NUM_REGS];

  // FSM control strobes consumed by the datapath
  logic cnt_clr, cnt_inc, sh_in, sh_load, sh_out;
  logic oe_set, oe_clr, ptr_load, ptr_inc, reg_wr;

  // Open-drain: only ever pull low or release
  assign sda  = oe ? 1'b0 : 1'bz;
  assign busy = (state != S_IDLE);

  assign scl_rise  = scl_s2 & ~scl_prev;
  assign scl_fall  = ~scl_s2 & scl_prev;
  // SCL must be high on both sides of the SDA edge to count as START/STOP
  assign start_det = scl_s2 & scl_prev & sda_prev & ~sda_s2;
  assign stop_det  = scl_s2 & scl_prev & ~sda_prev & sda_s2;

  // Two-FF synchronisers plus a history FF for edge strobes; idle bus is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_prev <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_prev <= 1'b1;
    end else begin
      scl_s1 <= scl;  scl_s2 <= scl_s1; scl_prev <= scl_s2;
      sda_s1 <= sda;  sda_s2 <= sda_s1; sda_prev <= sda_s2;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next state and datapath controls; START/STOP override every state
  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0; cnt_inc = 1'b0;
    sh_in    = 1'b0; sh_load = 1'b0; sh_out = 1'b0;
    oe_set   = 1'b0; oe_clr  = 1'b0;
    ptr_load = 1'b0; ptr_inc = 1'b0; reg_wr = 1'b0;
    if (start_det) begin
      state_n = S_ADDR; cnt_clr = 1'b1; oe_clr = 1'b1;
    end else if (stop_det) begin
      state_n = S_IDLE; oe_clr = 1'b1;
    end else begin
      case (state)
        S_IDLE, S_IGNORE: ;
        S_ADDR: begin
          if (scl_rise) begin
            sh_in = 1'b1; cnt_inc = 1'b1;
          end else if (scl_fall && cnt == 4'd8) begin
            if (sh[7:1] == SLAVE_ADDR) begin
              state_n = S_ACK_ADDR; oe_set = 1'b1;
            end else begin
              state_n = S_IGNORE;
            end
          end
        end
        // sh[0] still holds the R/W bit here
        S_ACK_ADDR: begin
          if (scl_fall) begin
            oe_clr = 1'b1; cnt_clr = 1'b1;
            if (sh[0]) begin
              state_n = S_RD_DATA; sh_load = 1'b1;
            end else begin
              state_n = S_PTR;
            end
          end
        end
        S_PTR: begin
          if (scl_rise) begin
            sh_in = 1'b1; cnt_inc = 1'b1;
          end else if (scl_fall && cnt == 4'd8) begin
            state_n = S_ACK_PTR; oe_set = 1'b1; ptr_load = 1'b1;
          end
        end
        S_ACK_PTR, S_ACK_WR: begin
          if (scl_fall) begin
            state_n = S_WR_DATA; oe_clr = 1'b1; cnt_clr = 1'b1;
          end
        end
        // The write commits on the 8th rise so an aborted byte never lands
        S_WR_DATA: begin
          if (scl_rise) begin
            sh_in = 1'b1; cnt_inc = 1'b1;
            if (cnt == 4'd7) reg_wr = 1'b1;
          end else if (scl_fall && cnt == 4'd8) begin
            state_n = S_ACK_WR; oe_set = 1'b1;
          end
        end
        S_RD_DATA: begin
          if (scl_rise) begin
            cnt_inc = 1'b1;
          end else if (scl_fall) begin
            if (cnt == 4'd8) begin
              state_n = S_RD_ACK; oe_clr = 1'b1;
            end else begin
              sh_out = 1'b1;
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s2) begin
              state_n = S_RD_LOAD; ptr_inc = 1'b1;
            end else begin
              state_n = S_IGNORE;
            end
          end
        end
        S_RD_LOAD: begin
          if (scl_fall) begin
            state_n = S_RD_DATA; sh_load = 1'b1; cnt_clr = 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Shift register, bit counter, pointer, SDA driver and register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      sh      <= '0;
      oe      <= 1'b0;
      ptr     <= '0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= REG_INIT;
    end else begin
      wr_stb <= reg_wr;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 4'd1;

      if (sh_in)        sh <= {sh[6:0], sda_s2};
      else if (sh_load) sh <= regs[ptr];
      else if (sh_out)  sh <= {sh[6:0], 1'b0};

      if (sh_load)      oe <= ~regs[ptr][7];
      else if (sh_out)  oe <= ~sh[6];
      else if (oe_set)  oe <= 1'b1;
      else if (oe_clr)  oe <= 1'b0;

      if (ptr_load)                ptr <= sh[PW-1:0];
      else if (ptr_inc || reg_wr)  ptr <= ptr + 1'b1;

      if (reg_wr) begin
        regs[ptr] <= {sh[6:0], sda_s2};
        wr_addr   <= ptr;
        wr_data   <= {sh[6:0], sda_s2};
      end
    end
  end

endmodule

// File: tb/tb_otter_i2c_slave.sv
// tb/tb_otter_i2c_slave.sv - scoreboard bench for otter_i2c_slave
`timescale 1ns/1ps
module tb_otter_i2c_slave;
  localparam int Q = 120;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  wire        sda;
  logic       busy, wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  int n_pass = 0;
  int n_total = 0;

  typedef struct { string name; logic [7:0] val; } exp_t;
  exp_t        bus_q[$];
  logic [7:0]  obs_q[$];
  logic [11:0] wr_q[$];

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  otter_i2c_slave dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
    .busy(busy), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic expect_bus(input string name, input logic [7:0] v);
    exp_t e;
    e.name = name; e.val = v;
    bus_q.push_back(e);
  endtask

  task automatic bit_io(input logic b, output logic r);
    m_low = ~b; #Q; scl = 1'b1; #Q; r = sda; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_start;
    m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop;
    m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #Q;
  endtask

  task automatic tx_byte(input logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(b[i], r);
    bit_io(1'b1, r);
    obs_q.push_back({7'd0, r});
  endtask

  task automatic rx_byte(input logic nack);
    logic [7:0] d;
    logic r;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_io(1'b1, r);
      d = {d[6:0], r};
    end
    bit_io(nack, r);
    obs_q.push_back(d);
  endtask

  task automatic wr_txn(input logic [7:0] p, input logic [7:0] d0, input logic [7:0] d1);
    expect_bus("ack_addr_w", 8'h00); expect_bus("ack_ptr", 8'h00);
    expect_bus("ack_d0", 8'h00);     expect_bus("ack_d1", 8'h00);
    wr_q.push_back({p[3:0], d0});
    wr_q.push_back({p[3:0] + 4'd1, d1});
    i2c_start; tx_byte(8'h90); tx_byte(p); tx_byte(d0); tx_byte(d1); i2c_stop;
  endtask

  task automatic rd_txn(input logic [7:0] p, input int n, input logic [7:0] e0, input logic [7:0] e1);
    expect_bus("ack_addr_w", 8'h00); expect_bus("ack_ptr", 8'h00);
    expect_bus("ack_addr_r", 8'h00); expect_bus("rd_byte0", e0);
    if (n == 2) expect_bus("rd_byte1", e1);
    i2c_start; tx_byte(8'h90); tx_byte(p); i2c_start; tx_byte(8'h91);
    rx_byte(n == 1);
    if (n == 2) rx_byte(1'b1);
    check("sda_released_after_nack", {7'd0, sda}, 8'h01);
    i2c_stop;
  endtask

  // Bus monitor: pair each master observation with the next expected value
  always @(negedge clk) begin : mon_bus
    exp_t e;
    logic [7:0] o;
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (bus_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_obs: got %h expected nothing", o);
      end else begin
        e = bus_q.pop_front();
        check(e.name, o, e.val);
      end
    end
  end

  // Write-strobe monitor
  always @(negedge clk) begin : mon_wr
    logic [11:0] w;
    if (rst_n && wr_stb) begin
      if (wr_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_wr_stb: got %h/%h expected none", wr_addr, wr_data);
      end else begin
        w = wr_q.pop_front();
        check("wr_addr", {4'd0, wr_addr}, {4'd0, w[11:8]});
        check("wr_data", wr_data, w[7:0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r;
    #3;
    rst_n = 1'b0; #40;
    check("rst_sda", {7'd0, sda}, 8'h01);
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_wr_stb", {7'd0, wr_stb}, 8'h00);
    check("rst_wr_addr", {4'd0, wr_addr}, 8'h00);
    check("rst_wr_data", wr_data, 8'h00);
    rst_n = 1'b1; #100;

    rd_txn(8'h00, 1, 8'h00, 8'h00);

    expect_bus("ack_addr_w", 8'h00); expect_bus("ack_ptr", 8'h00);
    expect_bus("ack_d0", 8'h00);     expect_bus("ack_d1", 8'h00);
    wr_q.push_back({4'h3, 8'hA5});
    wr_q.push_back({4'h4, 8'h5A});
    i2c_start;
    check("busy_after_start", {7'd0, busy}, 8'h01);
    tx_byte(8'h90); tx_byte(8'h03); tx_byte(8'hA5); tx_byte(8'h5A);
    i2c_stop; #Q;
    check("busy_after_stop", {7'd0, busy}, 8'h00);

    rd_txn(8'h03, 2, 8'hA5, 8'h5A);

    expect_bus("nack_bad_addr", 8'h01); expect_bus("nack_bad_data", 8'h01);
    i2c_start; tx_byte(8'h92); tx_byte(8'h00); i2c_stop;
    rd_txn(8'h03, 1, 8'hA5, 8'h00);

    wr_txn(8'h0F, 8'h11, 8'h22);
    rd_txn(8'h0F, 2, 8'h11, 8'h22);

    expect_bus("ack_addr_w", 8'h00); expect_bus("ack_ptr", 8'h00);
    i2c_start; tx_byte(8'h90); tx_byte(8'h07);
    for (int i = 0; i < 4; i++) bit_io(1'b1, r);
    i2c_stop; #Q;
    check("busy_after_abort_stop", {7'd0, busy}, 8'h00);
    rd_txn(8'h07, 1, 8'h00, 8'h00);

    expect_bus("ack_addr_w", 8'h00); expect_bus("ack_ptr", 8'h00);
    expect_bus("ack_addr_r", 8'h00);
    i2c_start; tx_byte(8'h90); tx_byte(8'h04); i2c_start; tx_byte(8'h91);
    check("rd_msb_driven", {7'd0, sda}, 8'h00);
    rst_n = 1'b0; #1;
    check("rst_mid_read_sda", {7'd0, sda}, 8'h01);
    check("rst_mid_read_busy", {7'd0, busy}, 8'h00);
    #40; rst_n = 1'b1;
    m_low = 1'b0; #Q; scl = 1'b1; #Q;
    rd_txn(8'h04, 1, 8'h00, 8'h00);

    #400;
    n_total++;
    if (bus_q.size() == 0 && obs_q.size() == 0) n_pass++;
    else $display("FAIL bus_queue_drain: got %0d/%0d left expected 0/0", bus_q.size(), obs_q.size());
    n_total++;
    if (wr_q.size() == 0) n_pass++;
    else $display("FAIL wr_queue_drain: got %0d left expected 0", wr_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
